wb_bram4k: RTL and testbench

WB_BRAM4K -- requirements
Module: wb_bram4k

---
 rtl/wb_bram4k.sv | 146 ++++++++++++++
 tb/tb_wb_bram4k.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_bram4k.sv
// wb_bram4k: 4 KiB (1024 x 32) Wishbone block RAM slave.
// Supports classic cycles, incrementing bursts (linear and wrap-4/8/16),
// and constant-address bursts. Reserved cycle types get an error acknowledge.
// Burst read data is prefetched, so a burst acks one beat per clock.
module wb_bram4k #(
  parameter int HIGHZ   = 0,
  parameter int ADDRESS = 25
) (
  input  logic               wb_clk_i,
  input  logic               wb_rst_i,
  input  logic               wb_cyc_i,
  input  logic               wb_stb_i,
  input  logic               wb_we_i,
  input  logic [2:0]         wb_cti_i,
  input  logic [1:0]         wb_bte_i,
  input  logic [ADDRESS-1:0] wb_adr_i,
  input  logic [3:0]         wb_sel_i,
  input  logic [31:0]        wb_dat_i,
  output logic               wb_ack_o,
  output logic               wb_err_o,
  output logic [31:0]        wb_dat_o,
  output logic [3:0]         wb_sel_o
);

  typedef enum logic [2:0] {
    CTI_CLASSIC = 3'b000,
    CTI_CONST   = 3'b001,
    CTI_INCR    = 3'b010,
    CTI_END     = 3'b111
  } cti_e;

  typedef enum logic [1:0] {
    BTE_LINEAR = 2'b00,
    BTE_WRAP4  = 2'b01,
    BTE_WRAP8  = 2'b10,
    BTE_WRAP16 = 2'b11
  } bte_e;

  // Storage and the registered RAM read port.
  logic [31:0] mem_q [1024];
  logic [31:0] rd_data_q;

  // Control state: registered ack/err, index of the word sitting in rd_data_q,
  // and the last word returned by a read (held on the bus between cycles).
  logic        ack_q,  ack_d;
  logic        err_q,  err_d;
  logic [9:0]  idx_q,  idx_d;
  logic [31:0] last_q, last_d;

  logic       sel;
  logic       reserved_cti;
  logic       start;
  logic       cont;
  logic       ack_int;
  logic       err_int;
  logic       wr_en;
  logic [9:0] next_idx;
  logic [9:0] rd_addr;
  logic [3:0] sel_int;

  // Only word-index bits are decoded; the rest are intentionally ignored.
  logic adr_unused;
  assign adr_unused = ^{wb_adr_i[ADDRESS-1:12], wb_adr_i[1:0]};

  assign sel          = wb_cyc_i & wb_stb_i;
  assign reserved_cti = !(wb_cti_i inside {CTI_CLASSIC, CTI_CONST, CTI_INCR, CTI_END});

  // Acks are only visible while selected, so a dropped strobe kills the beat
  // immediately even if ack_q was already set for it.
  assign ack_int = ack_q & sel;
  assign err_int = err_q & sel;

  // A new beat may only start after an idle cycle, giving classic cycles
  // their one-beat-per-two-clocks rhythm; a burst continues only from a
  // beat being acked with a non-final burst cycle type.
  assign start = sel & ~ack_q & ~err_q;
  assign cont  = ack_int & (wb_cti_i == CTI_INCR || wb_cti_i == CTI_CONST);

  assign wr_en = ack_int & wb_we_i & ~wb_rst_i;

  // Next burst word index: linear wraps the whole RAM, wrap-N keeps the upper bits.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    next_idx = idx_q;
    if (wb_cti_i == CTI_INCR) begin
      unique case (bte_e'(wb_bte_i))
        BTE_LINEAR: next_idx = idx_q + 10'd1;
        BTE_WRAP4:  next_idx = {idx_q[9:2], idx_q[1:0] + 2'd1};
        BTE_WRAP8:  next_idx = {idx_q[9:3], idx_q[2:0] + 3'd1};
        BTE_WRAP16: next_idx = {idx_q[9:4], idx_q[3:0] + 4'd1};
      endcase
    end
  end

  // Next-state logic for ack/err, the prefetch address and the held read word.
  always_comb begin
    ack_d   = sel & ((start & ~reserved_cti) | cont);
    err_d   = start & reserved_cti;
    rd_addr = cont ? next_idx : wb_adr_i[11:2];
    idx_d   = rd_addr;
    last_d  = (ack_int & ~wb_we_i) ? rd_data_q : last_q;
    sel_int = (ack_int & ~wb_we_i) ? 4'hF : 4'h0;
  end

  // Control registers with synchronous reset; reset terminates any burst.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (wb_rst_i) begin
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
      idx_q  <= '0;
      last_q <= '0;
    end else begin
      ack_q  <= ack_d;
      err_q  <= err_d;
      idx_q  <= idx_d;
      last_q <= last_d;
    end
  end

  // RAM: byte-lane writes at the acked beat's index, registered read of the prefetch address.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: the memory array has no reset so it maps onto block RAM.
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (wb_sel_i[b]) mem_q[idx_q][8*b +: 8] <= wb_dat_i[8*b +: 8];
      end
    end
    rd_data_q <= mem_q[rd_addr];
  end

  generate
    if (HIGHZ != 0) begin : g_highz
      assign wb_ack_o = sel ? ack_int : 1'bz;
      assign wb_err_o = sel ? err_int : 1'bz;
      assign wb_dat_o = sel ? last_d  : {32{1'bz}};
      assign wb_sel_o = sel ? sel_int : {4{1'bz}};
    end else begin : g_driven
      assign wb_ack_o = ack_int;
      assign wb_err_o = err_int;
      assign wb_dat_o = last_d;
      assign wb_sel_o = sel_int;
    end
  endgenerate

endmodule

// File: tb/tb_wb_bram4k.sv
// Directed bench for wb_bram4k: classic/byte writes, linear, wrap-4 and
// constant bursts, reserved cycle type error, and reset during a burst.
`timescale 1ns/1ps
module tb_wb_bram4k;

  logic        clk;
  logic        rst;
  logic        cyc, stb, we;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic [24:0] adr;
  logic [3:0]  sel;
  logic [31:0] dat_i;
  logic        ack, err;
  logic [31:0] dat_o;
  logic [3:0]  sel_o;

  int n_total = 0;
  int n_bad   = 0;

  logic [31:0] ev [8];

  wb_bram4k #(.HIGHZ(0), .ADDRESS(25)) dut (
    .wb_clk_i (clk),
    .wb_rst_i (rst),
    .wb_cyc_i (cyc),
    .wb_stb_i (stb),
    .wb_we_i  (we),
    .wb_cti_i (cti),
    .wb_bte_i (bte),
    .wb_adr_i (adr),
    .wb_sel_i (sel),
    .wb_dat_i (dat_i),
    .wb_ack_o (ack),
    .wb_err_o (err),
    .wb_dat_o (dat_o),
    .wb_sel_o (sel_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc = 0; stb = 0; we = 0; cti = 3'b000; bte = 2'b00;
    adr = '0; sel = 4'h0; dat_i = '0;
  endtask

  // Classic write: ack must appear exactly one cycle after selection.
  task automatic classic_write(input logic [24:0] a, input logic [31:0] d, input logic [3:0] s);
    cyc = 1; stb = 1; we = 1; cti = 3'b000; adr = a; dat_i = d; sel = s;
    @(negedge clk); check("wr_c0_ack", ack, 0);
    next_cycle();
    @(negedge clk); check("wr_c1_ack", ack, 1);
    next_cycle();
    idle();
    next_cycle();
  endtask

  // Classic read; with hold the strobe stays high to see the ack gap and second ack.
  task automatic classic_read(input logic [24:0] a, input logic [31:0] e, input bit hold);
    cyc = 1; stb = 1; we = 0; cti = 3'b000; adr = a; sel = 4'h0;
    @(negedge clk); check("rd_c0_ack", ack, 0);
    next_cycle();
    @(negedge clk);
    check("rd_c1_ack", ack, 1);
    check("rd_c1_dat", dat_o, e);
    check("rd_c1_sel", sel_o, 4'hF);
    if (hold) begin
      next_cycle();
      @(negedge clk);
      check("rd_c2_ack_gap", ack, 0);
      check("rd_c2_sel", sel_o, 4'h0);
      check("rd_c2_dat_hold", dat_o, e);
      next_cycle();
      @(negedge clk);
      check("rd_c3_ack", ack, 1);
      check("rd_c3_dat", dat_o, e);
    end
    next_cycle();
    idle();
    @(negedge clk);
    check("rd_idle_ack", ack, 0);
    check("rd_idle_dat_hold", dat_o, e);
    next_cycle();
  endtask

  // Burst read of n beats (cti_v on all but the last, 111 on the last).
  task automatic burst_read(input logic [24:0] a, input logic [1:0] b, input logic [2:0] cti_v,
                            input int n, input logic [31:0] e [8]);
    cyc = 1; stb = 1; we = 0; bte = b; adr = a; sel = 4'h0;
    cti = (n == 1) ? 3'b111 : cti_v;
    @(negedge clk); check("bu_c0_ack", ack, 0);
    for (int j = 1; j <= n; j++) begin
      next_cycle();
      cti = (j == n) ? 3'b111 : cti_v;
      @(negedge clk);
      check($sformatf("bu_beat%0d_ack", j - 1), ack, 1);
      check($sformatf("bu_beat%0d_dat", j - 1), dat_o, e[j-1]);
    end
    next_cycle();
    cti = 3'b000;
    @(negedge clk); check("bu_after_ack", ack, 0);
    next_cycle();
    idle();
    next_cycle();
  endtask

  initial begin
    idle();
    rst = 1;
    repeat (3) next_cycle();
    @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_err", err, 0);
    check("rst_sel", sel_o, 4'h0);
    check("rst_dat", dat_o, 32'h0);
    next_cycle();
    rst = 0;
    next_cycle();

    // Full word write then classic read with the strobe held.
    classic_write(25'h010, 32'hDEADBEEF, 4'hF);
    classic_read(25'h010, 32'hDEADBEEF, 1'b1);

    // Byte-lane write touches only lane 0.
    classic_write(25'h010, 32'h000000AA, 4'h1);
    classic_read(25'h010, 32'hDEADBEAA, 1'b0);

    // Words 0..7 at 0x100.., then a linear 8-beat burst.
    for (int k = 0; k < 8; k++) classic_write(25'h100 + 25'(4 * k), 32'(k), 4'hF);
    ev = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5, 32'd6, 32'd7};
    burst_read(25'h100, 2'b00, 3'b010, 8, ev);

    // Wrap-4 from word 2 of the block.
    ev = '{32'd2, 32'd3, 32'd0, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0};
    burst_read(25'h108, 2'b01, 3'b010, 4, ev);

    // Constant-address burst repeats the same word.
    ev = '{32'd3, 32'd3, 32'd3, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    burst_read(25'h10C, 2'b00, 3'b001, 3, ev);

    // Reserved cycle type: one err pulse, no ack, no write.
    classic_write(25'h020, 32'h12345678, 4'hF);
    cyc = 1; stb = 1; we = 1; cti = 3'b011; adr = 25'h020; dat_i = 32'hFFFFFFFF; sel = 4'hF;
    @(negedge clk);
    check("err_c0_err", err, 0);
    check("err_c0_ack", ack, 0);
    next_cycle();
    @(negedge clk);
    check("err_c1_err", err, 1);
    check("err_c1_ack", ack, 0);
    next_cycle();
    @(negedge clk);
    check("err_c2_err", err, 0);
    check("err_c2_ack", ack, 0);
    next_cycle();
    idle();
    next_cycle();
    classic_read(25'h020, 32'h12345678, 1'b0);

    // Reset asserted during the third beat of a linear burst.
    cyc = 1; stb = 1; we = 0; cti = 3'b010; bte = 2'b00; adr = 25'h100;
    @(negedge clk); check("rb_c0_ack", ack, 0);
    next_cycle();
    @(negedge clk); check("rb_beat0_dat", dat_o, 32'd0);
    next_cycle();
    @(negedge clk); check("rb_beat1_dat", dat_o, 32'd1);
    next_cycle();
    rst = 1;
    @(negedge clk);
    check("rb_beat2_ack", ack, 1);
    check("rb_beat2_dat", dat_o, 32'd2);
    next_cycle();
    rst = 0;
    idle();
    @(negedge clk);
    check("rb_after_rst_ack", ack, 0);
    check("rb_after_rst_dat", dat_o, 32'h0);
    next_cycle();
    classic_read(25'h104, 32'd1, 1'b0);
    classic_read(25'h010, 32'hDEADBEAA, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
